// File: rtl/pad_frame_pkg.sv
// Shared definitions for the pad-control frame: config bit positions,
// edge-mode and config-FSM encodings, and the edge-match helper.
package pad_frame_pkg;

  localparam int CFG_PEN      = 0;
  localparam int CFG_FILT     = 1;
  localparam int CFG_EDGE_LSB = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    APPLY = 2'd2,
    POST  = 2'd3
  } cfg_state_e;

  // Decide whether an observed transition is one the pad's edge mode reports.
  function automatic logic edge_hit(edge_mode_e mode, logic rise, logic fall);
    case (mode)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pad_in_filter.sv
// One pad's input path: 2-flop synchroniser, programmable glitch filter
// and registered edge-event detector.
module pad_in_filter
  import pad_frame_pkg::*;
#(
  parameter int FILT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pad_in_i,
  input  logic              filt_en_i,
  input  logic [1:0]        edge_mode_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              io_in_o,
  output logic              evt_o
);

  logic              s1;
  logic              s2;
  logic              prev;
  logic              filt_en_q;
  logic [FILT_W-1:0] cnt;

  // Synchronise, filter and detect edges; a filter enable toggle only clears
  // the counter so the filtered level never jumps on reconfiguration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      prev      <= 1'b0;
      filt_en_q <= 1'b0;
      cnt       <= '0;
      io_in_o   <= 1'b0;
      evt_o     <= 1'b0;
    end else begin
      s1        <= pad_in_i;
      s2        <= s1;
      prev      <= io_in_o;
      filt_en_q <= filt_en_i;
      evt_o     <= edge_hit(edge_mode_e'(edge_mode_i), io_in_o & ~prev, ~io_in_o & prev);
      if (filt_en_i != filt_en_q) begin
        cnt <= '0;
      end else if (!filt_en_i) begin
        io_in_o <= s2;
        cnt     <= '0;
      end else if (s2 == io_in_o) begin
        cnt <= '0;
      end else if (cnt == filt_len_i) begin
        io_in_o <= s2;
        cnt     <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_frame_filter.sv
// Pad-control frame: per-pad config registers written through a
// break-before-make sequence, plus one input filter per pad.
module pad_frame_filter
  import pad_frame_pkg::*;
#(
  parameter  int N_IO        = 63,
  parameter  int NBIT_PADCFG = 6,
  parameter  int FILT_W      = 4,
  parameter  int GUARD_CYC   = 2,
  localparam int IDX_W       = (N_IO > 1) ? $clog2(N_IO) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [IDX_W-1:0]            cfg_idx_i,
  input  logic [NBIT_PADCFG-1:0]      cfg_data_i,
  output logic                        cfg_err_o,
  input  logic [FILT_W-1:0]           filt_len_i,
  input  logic [N_IO-1:0]             io_out_i,
  input  logic [N_IO-1:0]             io_oe_i,
  output logic [N_IO-1:0]             io_in_o,
  output logic [N_IO-1:0]             evt_o,
  input  logic [N_IO-1:0]             pad_in_i,
  output logic [N_IO-1:0]             pad_out_o,
  output logic [N_IO-1:0]             pad_oe_o,
  output logic [N_IO-1:0]             pad_pen_o,
  output logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_o
);

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_PRE   = PRE;
  localparam logic [1:0] ST_APPLY = APPLY;
  localparam logic [1:0] ST_POST  = POST;

  logic [1:0]             state;
  logic [GW-1:0]          gcnt;
  logic [IDX_W-1:0]       idx_q;
  logic [NBIT_PADCFG-1:0] data_q;
  logic [NBIT_PADCFG-1:0] cfg_q [N_IO];
  logic [N_IO-1:0]        guard;
  logic                   idx_oob;

  assign idx_oob     = 32'(cfg_idx_i) >= 32'(N_IO);
  assign cfg_ready_o = (state == ST_IDLE);
  assign pad_out_o   = io_out_i;
  assign pad_oe_o    = io_oe_i & ~guard & {N_IO{~rst_i}};

  // Sequence a config write: guard the target pad, apply, guard again.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      gcnt      <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            if (idx_oob) begin
              cfg_err_o <= 1'b1;
            end else begin
              idx_q  <= cfg_idx_i;
              data_q <= cfg_data_i;
              gcnt   <= GUARD_LOAD;
              state  <= ST_PRE;
            end
          end
        end
        ST_PRE: begin
          if (gcnt == '0) state <= ST_APPLY;
          else            gcnt  <= gcnt - 1'b1;
        end
        ST_APPLY: begin
          gcnt  <= GUARD_LOAD;
          state <= ST_POST;
        end
        ST_POST: begin
          if (gcnt == '0) state <= ST_IDLE;
          else            gcnt  <= gcnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Commit the latched config to the target pad during APPLY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_IO; k++) cfg_q[k] <= '0;
    end else if (state == ST_APPLY) begin
      for (int k = 0; k < N_IO; k++) begin
        if (idx_q == IDX_W'(k)) cfg_q[k] <= data_q;
      end
    end
  end

  // Only the pad under reconfiguration has its output enable held off.
  always_comb begin
    guard = '0;
    for (int k = 0; k < N_IO; k++) begin
      guard[k] = (state != ST_IDLE) && (idx_q == IDX_W'(k));
    end
  end

  for (genvar k = 0; k < N_IO; k++) begin : g_pad
    assign pad_cfg_o[k*NBIT_PADCFG +: NBIT_PADCFG] = cfg_q[k];
    assign pad_pen_o[k] = cfg_q[k][CFG_PEN];

    pad_in_filter #(.FILT_W(FILT_W)) u_pad (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .pad_in_i    (pad_in_i[k]),
      .filt_en_i   (cfg_q[k][CFG_FILT]),
      .edge_mode_i (cfg_q[k][CFG_EDGE_LSB +: 2]),
      .filt_len_i  (filt_len_i),
      .io_in_o     (io_in_o[k]),
      .evt_o       (evt_o[k])
    );
  end

endmodule

// File: tb/tb_pad_frame_filter.sv
// Directed bench for pad_frame_filter: guard timing, filter, edge events,
// error pulses and asynchronous reset mid-sequence.
module tb_pad_frame_filter;

  localparam int N_IO = 63;
  localparam int NB   = 6;
  localparam int FW   = 4;
  localparam logic [N_IO-1:0] ALL1 = {N_IO{1'b1}};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [5:0]           cfg_idx;
  logic [NB-1:0]        cfg_data;
  logic                 cfg_err;
  logic [FW-1:0]        filt_len;
  logic [N_IO-1:0]      io_out;
  logic [N_IO-1:0]      io_oe;
  logic [N_IO-1:0]      io_in;
  logic [N_IO-1:0]      evt;
  logic [N_IO-1:0]      pad_in;
  logic [N_IO-1:0]      pad_out;
  logic [N_IO-1:0]      pad_oe;
  logic [N_IO-1:0]      pad_pen;
  logic [N_IO*NB-1:0]   pad_cfg;

  logic [NB-1:0] exp_cfg [N_IO];
  int checks = 0;
  int errors = 0;

  pad_frame_filter #(.N_IO(N_IO), .NBIT_PADCFG(NB), .FILT_W(FW), .GUARD_CYC(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_idx_i   (cfg_idx),
    .cfg_data_i  (cfg_data),
    .cfg_err_o   (cfg_err),
    .filt_len_i  (filt_len),
    .io_out_i    (io_out),
    .io_oe_i     (io_oe),
    .io_in_o     (io_in),
    .evt_o       (evt),
    .pad_in_i    (pad_in),
    .pad_out_o   (pad_out),
    .pad_oe_o    (pad_oe),
    .pad_pen_o   (pad_pen),
    .pad_cfg_o   (pad_cfg)
  );

  always #5 clk = ~clk;

  // Abort a runaway simulation with a visible failure.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_IO*NB-1:0] exp_flat();
    logic [N_IO*NB-1:0] f;
    for (int k = 0; k < N_IO; k++) f[k*NB +: NB] = exp_cfg[k];
    return f;
  endfunction

  // Present one config write and hold it until the frame accepts it.
  task automatic applyStimulus(input int idx, input logic [NB-1:0] data, output int waited);
    cfg_valid = 1'b1;
    cfg_idx   = 6'(idx);
    cfg_data  = data;
    waited    = 0;
    while (!cfg_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!cfg_ready) checkOutput("ready_timeout", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
    if (idx < N_IO) exp_cfg[idx] = data;
  endtask

  // Observe one pad for n cycles: first io_in high cycle, first event cycle, event count.
  task automatic watchPad(input int n, input int p, input logic lvl,
                          output int first_io, output int first_evt, output int evt_cnt);
    first_io  = -1;
    first_evt = -1;
    evt_cnt   = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (io_in[p] == lvl && first_io < 0) first_io = i;
      if (evt[p]) begin
        evt_cnt++;
        if (first_evt < 0) first_evt = i;
      end
    end
  endtask

  initial begin
    int w, fi, fe, ec, low_cnt;
    logic others_ok, seen;

    rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_data = '0;
    filt_len = '0; io_out = '0; io_oe = ALL1; pad_in = '0;
    for (int k = 0; k < N_IO; k++) exp_cfg[k] = '0;
    tick(); tick();
    checkOutput("rst_pad_oe", 64'(pad_oe), 64'd0);
    checkOutput("rst_ready", 64'(cfg_ready), 64'd1);
    rst = 1'b0;
    io_out = 63'h2A5A_5A5A_1234_5678;
    tick();
    checkOutput("oe_idle", 64'(pad_oe), 64'(ALL1));
    checkOutput("pad_out", 64'(pad_out), 64'h2A5A_5A5A_1234_5678);

    // Guard window on pad 5
    applyStimulus(5, 6'h01, w);
    checkOutput("g_accept_wait", 64'(w), 64'd0);
    checkOutput("g_ready_busy", 64'(cfg_ready), 64'd0);
    low_cnt = 0; others_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!pad_oe[5]) low_cnt++;
      if ((pad_oe | (63'd1 << 5)) != ALL1) others_ok = 1'b0;
      if (i == 2) checkOutput("pen_at_apply", 64'(pad_pen[5]), 64'd0);
      if (i == 3) checkOutput("pen_after_apply", 64'(pad_pen[5]), 64'd1);
      tick();
    end
    checkOutput("guard_len", 64'(low_cnt), 64'd5);
    checkOutput("guard_others", 64'(others_ok), 64'd1);
    checkOutput("cfg_after_g", 64'(pad_cfg == exp_flat()), 64'd1);

    // Back-to-back writes: second held off until the frame is idle again
    filt_len = 4'd3;
    applyStimulus(7, 6'h02, w);
    applyStimulus(9, 6'h0C, w);
    checkOutput("b2b_holdoff", 64'(w), 64'd5);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("b2b_ready", 64'(cfg_ready), 64'd1);
    checkOutput("cfg_after_b2b", 64'(pad_cfg == exp_flat()), 64'd1);

    // Glitch filter on pad 7, L=3: short pulse swallowed, long level passes
    pad_in[7] = 1'b1;
    tick(); tick(); tick();
    pad_in[7] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (io_in[7]) seen = 1'b1;
    end
    checkOutput("filt_short", 64'(seen), 64'd0);
    pad_in[7] = 1'b1;
    watchPad(12, 7, 1'b1, fi, fe, ec);
    checkOutput("filt_rise_lat", 64'(fi), 64'd6);
    pad_in[7] = 1'b0;
    watchPad(12, 7, 1'b0, fi, fe, ec);
    checkOutput("filt_fall_lat", 64'(fi), 64'd6);
    filt_len = 4'd0;
    pad_in[7] = 1'b1;
    watchPad(8, 7, 1'b1, fi, fe, ec);
    checkOutput("filt_l0_lat", 64'(fi), 64'd3);

    // Edge events on pad 9 (both edges, no filter)
    pad_in[9] = 1'b1;
    watchPad(8, 9, 1'b1, fi, fe, ec);
    checkOutput("edge_io_lat", 64'(fi), 64'd3);
    checkOutput("edge_rise_lat", 64'(fe), 64'd4);
    checkOutput("edge_rise_cnt", 64'(ec), 64'd1);
    pad_in[9] = 1'b0;
    watchPad(8, 9, 1'b0, fi, fe, ec);
    checkOutput("edge_fall_lat", 64'(fe), 64'd4);
    checkOutput("edge_fall_cnt", 64'(ec), 64'd1);
    pad_in[9] = 1'b1;
    watchPad(8, 9, 1'b1, fi, fe, ec);
    applyStimulus(9, 6'h04, w);
    checkOutput("mode_chg_evt0", 64'(evt[9]), 64'd0);
    watchPad(8, 9, 1'b1, fi, fe, ec);
    checkOutput("mode_chg_no_evt", 64'(ec), 64'd0);
    pad_in[9] = 1'b0;
    watchPad(8, 9, 1'b0, fi, fe, ec);
    checkOutput("rise_mode_fall", 64'(ec), 64'd0);
    pad_in[9] = 1'b1;
    watchPad(8, 9, 1'b1, fi, fe, ec);
    checkOutput("rise_mode_rise", 64'(ec), 64'd1);

    // Out-of-range index
    applyStimulus(63, 6'h3F, w);
    checkOutput("err_pulse", 64'(cfg_err), 64'd1);
    checkOutput("err_ready", 64'(cfg_ready), 64'd1);
    tick();
    checkOutput("err_clear", 64'(cfg_err), 64'd0);
    checkOutput("cfg_after_err", 64'(pad_cfg == exp_flat()), 64'd1);

    // Reset asserted during POST
    applyStimulus(3, 6'h3F, w);
    tick(); tick(); tick();
    checkOutput("post_guard", 64'(pad_oe[3]), 64'd0);
    checkOutput("post_pen", 64'(pad_pen[3]), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_oe_now", 64'(pad_oe), 64'd0);
    checkOutput("rst_cfg_now", 64'(pad_cfg == '0), 64'd1);
    checkOutput("rst_pen_now", 64'(pad_pen), 64'd0);
    checkOutput("rst_io_in_now", 64'(io_in), 64'd0);
    checkOutput("rst_evt_now", 64'(evt), 64'd0);
    checkOutput("rst_err_now", 64'(cfg_err), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < N_IO; k++) exp_cfg[k] = '0;
    #1;
    checkOutput("rel_ready", 64'(cfg_ready), 64'd1);
    checkOutput("rel_oe", 64'(pad_oe), 64'(ALL1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
